// File: rtl/key_conditioner_if.sv
// rtl/key_conditioner_if.sv - raw key inputs and conditioned key/boost outputs
interface key_conditioner_if #(
    parameter int NUM_KEYS = 4,
    parameter int BOOST_W  = 6
);
    logic [NUM_KEYS-1:0] KEY;
    logic [NUM_KEYS-1:0] key_level;
    logic [NUM_KEYS-1:0] key_press;
    logic [NUM_KEYS-1:0] key_release;
    logic [BOOST_W-1:0]  boost;
    logic                boost_tick;

    modport master (
        input  KEY,
        output key_level,
        output key_press,
        output key_release,
        output boost,
        output boost_tick
    );

    modport slave (
        output KEY,
        input  key_level,
        input  key_press,
        input  key_release,
        input  boost,
        input  boost_tick
    );
endinterface

// File: rtl/key_conditioner.sv
// rtl/key_conditioner.sv - push-button synchroniser, debouncer and paddle boost ramp
module key_conditioner #(
    parameter int NUM_KEYS        = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int BOOST_PERIOD    = 8388608,
    parameter int BOOST_MAX       = 63,
    parameter int BOOST_W         = 6
) (
    input logic               CLOCK_50,
    input logic               RESET_N,
    key_conditioner_if.master keys
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int PRE_W = (BOOST_PERIOD > 1) ? $clog2(BOOST_PERIOD) : 1;
    localparam int HOLD_HI = (NUM_KEYS > 1) ? 1 : 0;

    localparam logic [CNT_W-1:0]   CNT_TERM  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
    localparam logic [PRE_W-1:0]   PRE_LAST  = PRE_W'(BOOST_PERIOD - 1);
    localparam logic [PRE_W-1:0]   PRE_ONE   = PRE_W'(1);
    localparam logic [BOOST_W-1:0] BOOST_TOP = BOOST_W'(BOOST_MAX);
    localparam logic [BOOST_W-1:0] BOOST_MIN = BOOST_W'(1);

    typedef enum logic [1:0] {
        ST_UP     = 2'd0,
        ST_CHK_DN = 2'd1,
        ST_DOWN   = 2'd2,
        ST_CHK_UP = 2'd3
    } key_state_t;

    logic [NUM_KEYS-1:0] sync_a;
    logic [NUM_KEYS-1:0] sync_b;
    logic [NUM_KEYS-1:0] s;
    logic [NUM_KEYS-1:0] level;
    logic [NUM_KEYS-1:0] press;
    logic [NUM_KEYS-1:0] rel;

    logic [PRE_W-1:0]   presc;
    logic               tick;
    logic               hold;
    logic [BOOST_W-1:0] boost;

    // Flops hold the raw active-low level, so reset value 1 means "released".
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            sync_a <= '1;
            sync_b <= '1;
        end else begin
            sync_a <= keys.KEY;
            sync_b <= sync_a;
        end
    end

    assign s = ~sync_b;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        key_state_t       state;
        key_state_t       state_nxt;
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] cnt_nxt;
        logic [CNT_W-1:0] cnt_inc;
        logic             lvl;
        logic             press_nxt;
        logic             rel_nxt;
        logic             press_q;
        logic             rel_q;

        assign cnt_inc = cnt + CNT_ONE;

        always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
            if (!RESET_N) begin
                state   <= ST_UP;
                cnt     <= '0;
                press_q <= 1'b0;
                rel_q   <= 1'b0;
            end else begin
                state   <= state_nxt;
                cnt     <= cnt_nxt;
                press_q <= press_nxt;
                rel_q   <= rel_nxt;
            end
        end

        // The sample that leaves UP/DOWN is the first of the stable run, so the
        // run is complete when the incremented count reaches the terminal value.
        always_comb begin
            state_nxt = state;
            cnt_nxt   = cnt;
            case (state)
                ST_UP: begin
                    if (s[i]) begin
                        state_nxt = ST_CHK_DN;
                        cnt_nxt   = '0;
                    end
                end
                ST_CHK_DN: begin
                    if (!s[i]) begin
                        state_nxt = ST_UP;
                    end else if (cnt_inc >= CNT_TERM) begin
                        state_nxt = ST_DOWN;
                        cnt_nxt   = CNT_TERM;
                    end else begin
                        cnt_nxt = cnt_inc;
                    end
                end
                ST_DOWN: begin
                    if (!s[i]) begin
                        state_nxt = ST_CHK_UP;
                        cnt_nxt   = '0;
                    end
                end
                ST_CHK_UP: begin
                    if (s[i]) begin
                        state_nxt = ST_DOWN;
                    end else if (cnt_inc >= CNT_TERM) begin
                        state_nxt = ST_UP;
                        cnt_nxt   = CNT_TERM;
                    end else begin
                        cnt_nxt = cnt_inc;
                    end
                end
                default: begin
                    state_nxt = ST_UP;
                    cnt_nxt   = '0;
                end
            endcase
        end

        always_comb begin
            lvl       = (state == ST_DOWN) || (state == ST_CHK_UP);
            press_nxt = (state == ST_CHK_DN) && (state_nxt == ST_DOWN);
            rel_nxt   = (state == ST_CHK_UP) && (state_nxt == ST_UP);
        end

        assign level[i] = lvl;
        assign press[i] = press_q;
        assign rel[i]   = rel_q;
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            presc <= '0;
        end else if (presc == PRE_LAST) begin
            presc <= '0;
        end else begin
            presc <= presc + PRE_ONE;
        end
    end

    assign tick = (presc == PRE_LAST);

    // Registered key levels gate the ramp, so a press accepted on a tick edge
    // does not bump boost until the next tick.
    assign hold = |level[HOLD_HI:0];

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            boost <= BOOST_MIN;
        end else if (!hold) begin
            boost <= BOOST_MIN;
        end else if (tick && (boost < BOOST_TOP)) begin
            boost <= boost + BOOST_MIN;
        end
    end

    assign keys.key_level   = level;
    assign keys.key_press   = press;
    assign keys.key_release = rel;
    assign keys.boost       = boost;
    assign keys.boost_tick  = tick;
endmodule

// File: tb/tb_key_conditioner.sv
// tb/tb_key_conditioner.sv - scoreboard bench for key_conditioner with a run-length reference model
module tb_key_conditioner;
    localparam int NK = 4;
    localparam int DB = 4;
    localparam int BP = 8;
    localparam int BM = 5;
    localparam int BW = 6;

    typedef struct packed {
        logic [NK-1:0] level;
        logic [NK-1:0] press;
        logic [NK-1:0] rel;
        logic [BW-1:0] boost;
        logic          tick;
    } out_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    key_conditioner_if #(.NUM_KEYS(NK), .BOOST_W(BW)) kif ();

    key_conditioner #(
        .NUM_KEYS(NK),
        .DEBOUNCE_CYCLES(DB),
        .BOOST_PERIOD(BP),
        .BOOST_MAX(BM),
        .BOOST_W(BW)
    ) dut (
        .CLOCK_50(clk),
        .RESET_N(rst_n),
        .keys(kif)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", name, got, want, $time);
        end
    endtask

    // Reference model: a key flips once its synchronised sample has held the
    // opposite value for DB consecutive cycles; boost follows the ramp rules.
    out_t          exp_q[$];
    logic [NK-1:0] pipe_q[$];
    int            run[NK];
    logic [NK-1:0] last_s;
    logic [NK-1:0] m_level;
    int            m_boost;
    int            cyc_cnt;

    task automatic model_reset();
        pipe_q.delete();
        pipe_q.push_back('0);
        pipe_q.push_back('0);
        for (int k = 0; k < NK; k++) run[k] = 0;
        last_s  = '0;
        m_level = '0;
        m_boost = 1;
        cyc_cnt = 0;
        exp_q.delete();
    endtask

    always @(posedge clk or negedge rst_n) begin : model
        logic [NK-1:0] s_now;
        logic [NK-1:0] pr;
        logic [NK-1:0] rl;
        logic          hold_pre;
        logic          tick_pre;
        out_t          rec;
        if (!rst_n) begin
            model_reset();
        end else begin
            s_now = pipe_q.pop_front();
            pipe_q.push_back(~kif.KEY);
            hold_pre = m_level[0] | m_level[1];
            tick_pre = ((cyc_cnt % BP) == BP - 1);
            for (int k = 0; k < NK; k++) begin
                if (s_now[k] == last_s[k]) run[k] = (run[k] < 1000) ? run[k] + 1 : run[k];
                else run[k] = 1;
                last_s[k] = s_now[k];
                pr[k] = !m_level[k] && s_now[k] && (run[k] >= DB);
                rl[k] = m_level[k] && !s_now[k] && (run[k] >= DB);
                if (pr[k]) m_level[k] = 1'b1;
                if (rl[k]) m_level[k] = 1'b0;
            end
            if (!hold_pre) m_boost = 1;
            else if (tick_pre && m_boost < BM) m_boost = m_boost + 1;
            cyc_cnt++;
            rec.level = m_level;
            rec.press = pr;
            rec.rel   = rl;
            rec.boost = BW'(m_boost);
            rec.tick  = ((cyc_cnt % BP) == BP - 1);
            exp_q.push_back(rec);
        end
    end

    always @(negedge clk) begin : monitor
        out_t want;
        logic have;
        have = 1'b1;
        if (!rst_n) begin
            want = '0;
            want.boost = BW'(1);
        end else if (exp_q.size() == 0) begin
            have = 1'b0;
            total++;
            bad++;
            $display("FAIL scoreboard_empty: got no record want one at %0t", $time);
        end else begin
            want = exp_q.pop_front();
        end
        if (have) begin
            chk("key_level",   int'(kif.key_level),   int'(want.level));
            chk("key_press",   int'(kif.key_press),   int'(want.press));
            chk("key_release", int'(kif.key_release), int'(want.rel));
            chk("boost",       int'(kif.boost),       int'(want.boost));
            chk("boost_tick",  int'(kif.boost_tick),  int'(want.tick));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic wait_pulse(input int k, input bit is_press, output int n);
        n = -1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (is_press ? kif.key_press[k] : kif.key_release[k]) begin
                n = c;
                break;
            end
        end
        #1;
    endtask

    initial begin : stim
        int n;
        int cnt;
        int last_b;
        int seq[$];
        int hold_left[NK];
        kif.KEY = '1;
        rst_n   = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        rst_n = 1'b1;
        cyc(100);

        kif.KEY[3] = 1'b0;
        wait_pulse(3, 1'b1, n);
        chk("press3_latency", n, 6);
        cyc(10);
        kif.KEY[3] = 1'b1;
        wait_pulse(3, 1'b0, n);
        chk("release3_latency", n, 6);
        cyc(10);

        kif.KEY[2] = 1'b0; cyc(1);
        kif.KEY[2] = 1'b1; cyc(1);
        kif.KEY[2] = 1'b0; cyc(1);
        kif.KEY[2] = 1'b1;
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (kif.key_press[2] || kif.key_level[2]) cnt++;
        end
        #1;
        chk("bounce2_activity", cnt, 0);

        kif.KEY[0] = 1'b0;
        seq.delete();
        seq.push_back(1);
        last_b = 1;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (int'(kif.boost) != last_b) begin
                last_b = int'(kif.boost);
                seq.push_back(last_b);
            end
        end
        #1;
        chk("ramp_steps", seq.size(), 5);
        for (int j = 0; j < seq.size() && j < 5; j++) chk("ramp_value", seq[j], j + 1);
        kif.KEY[0] = 1'b1;
        n = -1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (!kif.key_level[0]) begin
                n = c;
                break;
            end
        end
        chk("level0_fall", n, 6);
        chk("boost_at_fall", int'(kif.boost), 5);
        @(negedge clk);
        chk("boost_after_fall", int'(kif.boost), 1);
        #1;
        cyc(10);

        kif.KEY[1:0] = 2'b00;
        cyc(40);
        chk("dual_boost", int'(kif.boost), 5);
        kif.KEY[0] = 1'b1;
        cyc(30);
        chk("one_left_boost", int'(kif.boost), 5);
        kif.KEY[1] = 1'b1;
        cyc(15);
        chk("none_boost", int'(kif.boost), 1);

        kif.KEY[0] = 1'b0;
        n = -1;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (int'(kif.boost) == 3) begin
                n = c;
                break;
            end
        end
        #1;
        chk("reach_boost3", int'(n > 0), 1);
        kif.KEY[1] = 1'b0;
        cyc(3);
        rst_n = 1'b0;
        #1;
        chk("rst_level", int'(kif.key_level), 0);
        chk("rst_press", int'(kif.key_press), 0);
        chk("rst_boost", int'(kif.boost), 1);
        chk("rst_tick",  int'(kif.boost_tick), 0);
        kif.KEY[0] = 1'b1;
        cyc(3);
        rst_n = 1'b1;
        wait_pulse(1, 1'b1, n);
        chk("press1_after_reset", n, 6);
        kif.KEY[1] = 1'b1;
        cyc(20);

        for (int k = 0; k < NK; k++) hold_left[k] = 0;
        for (int c = 0; c < 800; c++) begin
            for (int k = 0; k < NK; k++) begin
                if (hold_left[k] == 0) begin
                    kif.KEY[k] = ~kif.KEY[k];
                    hold_left[k] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3))
                                                                : int'($urandom_range(4, 14));
                end else begin
                    hold_left[k]--;
                end
            end
            if ($urandom_range(0, 299) == 0) begin
                rst_n = 1'b0;
                cyc(2);
                rst_n = 1'b1;
            end
            cyc(1);
        end
        kif.KEY = '1;
        cyc(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
